// File: rtl/spike_packet_gen.sv
// spike_packet_gen: latches a timestep spike vector and streams one {src,dst} packet per CSR connection
//   CLK, reset          : clock, synchronous active-high reset
//   cfg_we/sel/idx/data : table write port (0 neuron addr, 1 CSR pointer, 2 connection), blocked while busy
//   spikes, spikes_valid: spike vector and start-of-timestep strobe
//   busy, done, overrun : status; overrun is sticky until reset
//   packet_valid/ready  : valid/ready handshake carrying packet = {neuron_addr[i], conn[j]}
module spike_packet_gen #(
   parameter int NUM_NEURONS = 10,
   parameter int ADDR_W      = 12,
   parameter int MAX_CONN    = 32,
   parameter int PTR_W       = $clog2(MAX_CONN + 1),
   parameter int IDX_W       = $clog2(MAX_CONN + 1)
) (
   input  logic                   CLK,
   input  logic                   reset,
   input  logic                   cfg_we,
   input  logic [1:0]             cfg_sel,
   input  logic [IDX_W-1:0]       cfg_idx,
   input  logic [ADDR_W-1:0]      cfg_data,
   input  logic [NUM_NEURONS-1:0] spikes,
   input  logic                   spikes_valid,
   output logic                   busy,
   output logic                   done,
   output logic                   overrun,
   output logic                   packet_valid,
   input  logic                   packet_ready,
   output logic [2*ADDR_W-1:0]    packet
);
   localparam int NW = $clog2(NUM_NEURONS + 1);
   localparam int CW = $clog2(MAX_CONN);
   localparam logic [1:0] S_IDLE = 2'd0, S_SCAN = 2'd1, S_EMIT = 2'd2, S_DONE = 2'd3;
   localparam logic [IDX_W-1:0] L_NN = IDX_W'(NUM_NEURONS);
   localparam logic [IDX_W-1:0] L_NC = IDX_W'(MAX_CONN);
   localparam logic [PTR_W-1:0] L_MC = PTR_W'(MAX_CONN);
   localparam logic [NW-1:0] L_LAST = NW'(NUM_NEURONS - 1);
   logic [ADDR_W-1:0]      r_naddr [NUM_NEURONS];
   logic [PTR_W-1:0]       r_ptr [NUM_NEURONS+1];
   logic [ADDR_W-1:0]      r_conn [MAX_CONN];
   logic [1:0]             r_state;
   logic [NUM_NEURONS-1:0] r_spk;
   logic [NW-1:0]          r_i;
   logic [PTR_W-1:0]       r_j;
   logic                   r_ovr;
   logic [2*ADDR_W-1:0]    r_pkt;
   logic [NW-1:0]          w_i1;
   logic [PTR_W-1:0]       w_lo, w_hi, w_j1;
   logic                   w_last;
   // Pointers beyond the table depth are clamped so the range never indexes past conn[].
   assign w_i1   = r_i + NW'(1);
   assign w_lo   = (r_ptr[r_i] > L_MC) ? L_MC : r_ptr[r_i];
   assign w_hi   = (r_ptr[w_i1] > L_MC) ? L_MC : r_ptr[w_i1];
   assign w_j1   = r_j + PTR_W'(1);
   assign w_last = r_i == L_LAST;
   assign busy         = r_state == S_SCAN || r_state == S_EMIT;
   assign done         = r_state == S_DONE;
   assign packet_valid = r_state == S_EMIT;
   assign overrun      = r_ovr;
   assign packet       = r_pkt;
   // Tables survive reset; writes are frozen for the whole in-flight timestep.
   always_ff @(posedge CLK) begin
      if (cfg_we && !busy) begin
         if (cfg_sel == 2'd0 && cfg_idx < L_NN) r_naddr[cfg_idx[NW-1:0]] <= cfg_data;
         if (cfg_sel == 2'd1 && cfg_idx <= L_NN) r_ptr[cfg_idx[NW-1:0]] <= cfg_data[PTR_W-1:0];
         if (cfg_sel == 2'd2 && cfg_idx < L_NC) r_conn[cfg_idx[CW-1:0]] <= cfg_data;
      end
   end
   always_ff @(posedge CLK) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_ovr   <= 1'b0;
         r_pkt   <= '0;
      end else begin
         if (spikes_valid && r_state != S_IDLE) r_ovr <= 1'b1;
         case (r_state)
            S_IDLE: if (spikes_valid) begin
               r_spk   <= spikes;
               r_i     <= '0;
               r_state <= (spikes == '0) ? S_DONE : S_SCAN;
            end
            S_SCAN: if (r_spk[r_i] && w_lo < w_hi) begin
               r_j     <= w_lo;
               r_pkt   <= {r_naddr[r_i], r_conn[w_lo[CW-1:0]]};
               r_state <= S_EMIT;
            end else if (w_last) r_state <= S_DONE;
            else r_i <= w_i1;
            // Back-to-back packets within one neuron's range keep 1 packet/cycle.
            S_EMIT: if (packet_ready) begin
               if (w_j1 < w_hi) begin
                  r_j   <= w_j1;
                  r_pkt <= {r_naddr[r_i], r_conn[w_j1[CW-1:0]]};
               end else if (w_last) r_state <= S_DONE;
               else begin
                  r_i     <= w_i1;
                  r_state <= S_SCAN;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spike_packet_gen.sv
// tb_spike_packet_gen: directed bench with a queue-based packet model and per-cycle compare
module tb_spike_packet_gen;
   localparam int NN = 10, AW = 12, MC = 32, IW = $clog2(MC + 1);
   logic CLK = 0, reset = 1, cfg_we = 0, spikes_valid = 0, packet_ready = 1;
   logic [1:0] cfg_sel = 0;
   logic [IW-1:0] cfg_idx = 0;
   logic [AW-1:0] cfg_data = 0;
   logic [NN-1:0] spikes = 0;
   logic busy, done, overrun, packet_valid;
   logic [2*AW-1:0] packet;
   int n_cmp = 0, n_bad = 0;
   logic [AW-1:0] m_naddr [NN];
   int m_ptr [NN+1];
   logic [AW-1:0] m_conn [MC];
   logic [2*AW-1:0] exp_q [$], got_q [$];
   int cnt, exp_done, stalls, done_at;
   bit active = 0;
   logic [2*AW-1:0] lit [3] = '{24'h100A01, 24'h100A02, 24'h102B05};
   int pv [NN+1] = '{0, 2, 2, 3, 3, 3, 3, 3, 3, 3, 3};
   spike_packet_gen dut (
      .CLK(CLK), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_idx(cfg_idx),
      .cfg_data(cfg_data), .spikes(spikes), .spikes_valid(spikes_valid), .busy(busy),
      .done(done), .overrun(overrun), .packet_valid(packet_valid), .packet_ready(packet_ready),
      .packet(packet)
   );
   always #5 CLK = ~CLK;
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask
   task automatic cfg_write(input int sel, input int idx, input int data, input bit upd);
      cfg_we = 1;
      cfg_sel = 2'(sel);
      cfg_idx = IW'(idx);
      cfg_data = AW'(data);
      @(posedge CLK);
      #1 cfg_we = 0;
      if (upd) begin
         if (sel == 0) m_naddr[idx] = AW'(data);
         else if (sel == 1) m_ptr[idx] = data;
         else if (sel == 2) m_conn[idx] = AW'(data);
      end
   endtask
   // Expected packets: every spiking neuron in ascending order, each over its clamped CSR range.
   task automatic start_ts(input logic [NN-1:0] spk);
      int lo, hi;
      exp_q.delete();
      got_q.delete();
      for (int n = 0; n < NN; n++) begin
         if (spk[n]) begin
            lo = m_ptr[n] > MC ? MC : m_ptr[n];
            hi = m_ptr[n+1] > MC ? MC : m_ptr[n+1];
            for (int j = lo; j < hi; j++) exp_q.push_back({m_naddr[n], m_conn[j]});
         end
      end
      // One cycle per neuron scanned plus one per packet, then the done cycle.
      exp_done = (spk == '0) ? 1 : NN + exp_q.size() + 1;
      stalls = 0;
      done_at = -1;
      spikes = spk;
      spikes_valid = 1;
      @(posedge CLK);
      #1 spikes_valid = 0;
      cnt = 0;
      active = 1;
   endtask
   task automatic pulse_sv(input logic [NN-1:0] spk);
      spikes = spk;
      spikes_valid = 1;
      @(posedge CLK);
      #1 spikes_valid = 0;
   endtask
   task automatic wait_done;
      for (int k = 0; k < 400 && active; k++) begin
         @(posedge CLK);
         #1;
      end
      if (active) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_done: got still active expected done within 400 cycles");
         active = 0;
      end
   endtask
   task automatic chk_s1;
      chk("s1_count", 32'(got_q.size()), 3);
      for (int k = 0; k < 3; k++)
         chk("s1_packet", k < got_q.size() ? 32'(got_q[k]) : 32'hFFFFFFFF, 32'(lit[k]));
   endtask
   always @(negedge CLK) begin
      if (active) begin
         cnt++;
         if (packet_valid) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL extra_packet: got %h expected none", packet);
            end else begin
               chk("packet", 32'(packet), 32'(exp_q[0]));
               if (packet_ready) begin
                  got_q.push_back(packet);
                  void'(exp_q.pop_front());
               end
            end
            if (!packet_ready) stalls++;
         end
         chk("busy", 32'(busy), 32'(cnt < exp_done + stalls));
         chk("done", 32'(done), 32'(cnt == exp_done + stalls));
         if (done || cnt >= exp_done + stalls) begin
            chk("drained", 32'(exp_q.size()), 0);
            done_at = cnt;
            active = 0;
         end
      end else if (!reset) begin
         chk("idle_valid", 32'(packet_valid), 0);
         chk("idle_done", 32'(done), 0);
      end
   end
   initial begin
      repeat (3) @(posedge CLK);
      #1 reset = 0;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_overrun", 32'(overrun), 0);
      chk("rst_valid", 32'(packet_valid), 0);
      chk("rst_packet", 32'(packet), 0);
      for (int n = 0; n < NN; n++) cfg_write(0, n, 'h100 + n, 1);
      for (int n = 0; n <= NN; n++) cfg_write(1, n, pv[n], 1);
      cfg_write(2, 0, 'hA01, 1);
      cfg_write(2, 1, 'hA02, 1);
      cfg_write(2, 2, 'hB05, 1);
      cfg_write(2, 30, 'hC1E, 1);
      cfg_write(2, 31, 'hC1F, 1);
      start_ts(10'b0000000101);
      wait_done();
      chk_s1();
      chk("s1_done_cycle", 32'(done_at), 14);
      start_ts(10'b0000000010);
      wait_done();
      chk("s2_count", 32'(got_q.size()), 0);
      chk("s2_done_cycle", 32'(done_at), 11);
      packet_ready = 0;
      start_ts(10'b0000000101);
      repeat (6) begin
         @(posedge CLK);
         #1;
      end
      packet_ready = 1;
      wait_done();
      chk_s1();
      chk("s3_done_cycle", 32'(done_at), 19);
      start_ts(10'b0000000101);
      @(posedge CLK);
      #1 pulse_sv(10'b0000001000);
      wait_done();
      chk_s1();
      chk("s4_done_cycle", 32'(done_at), 14);
      chk("s4_overrun", 32'(overrun), 1);
      start_ts('0);
      wait_done();
      chk("s4_empty_done_cycle", 32'(done_at), 1);
      chk("s4_overrun_sticky", 32'(overrun), 1);
      start_ts(10'b0000000101);
      cfg_write(2, 0, 'hFFF, 0);
      cfg_write(2, 2, 'hFFF, 0);
      wait_done();
      chk_s1();
      cfg_write(2, 0, 'hFFF, 1);
      cfg_write(2, 32, 'h777, 0);
      start_ts(10'b0000000001);
      wait_done();
      chk("s5_count", 32'(got_q.size()), 2);
      chk("s5_new_conn", got_q.size() > 0 ? 32'(got_q[0]) : 32'hFFFFFFFF, 32'h100FFF);
      cfg_write(2, 0, 'hA01, 1);
      cfg_write(1, 9, 30, 1);
      cfg_write(1, 10, 40, 1);
      start_ts(10'b1000000000);
      wait_done();
      chk("s6_count", 32'(got_q.size()), 2);
      chk("s6_first", got_q.size() > 0 ? 32'(got_q[0]) : 32'hFFFFFFFF, 32'h109C1E);
      chk("s6_last", got_q.size() > 1 ? 32'(got_q[1]) : 32'hFFFFFFFF, 32'h109C1F);
      chk("s6_done_cycle", 32'(done_at), 13);
      cfg_write(1, 9, 3, 1);
      cfg_write(1, 10, 3, 1);
      start_ts(10'b0000000101);
      @(posedge CLK);
      #1;
      @(posedge CLK);
      #1 reset = 1;
      @(posedge CLK);
      #1 reset = 0;
      active = 0;
      exp_q.delete();
      chk("s7_valid", 32'(packet_valid), 0);
      chk("s7_busy", 32'(busy), 0);
      chk("s7_done", 32'(done), 0);
      chk("s7_overrun", 32'(overrun), 0);
      chk("s7_packet", 32'(packet), 0);
      repeat (3) begin
         @(posedge CLK);
         #1;
      end
      start_ts(10'b0000000101);
      wait_done();
      chk_s1();
      chk("s7_done_cycle", 32'(done_at), 14);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
